// File: rtl/cv32e40p_apu_arbiter_if.sv
// rtl/cv32e40p_apu_arbiter_if.sv - shared FPU (APU) port bundle between arbiter and FP wrapper
interface cv32e40p_apu_arbiter_if #(
  parameter int APU_NARGS    = 3,
  parameter int APU_WOP      = 6,
  parameter int APU_NDSFLAGS = 15,
  parameter int APU_NUSFLAGS = 5
) ();
  logic                             apu_req_o;
  logic                             apu_gnt_i;
  logic [APU_NARGS-1:0][31:0]       apu_operands_o;
  logic [APU_WOP-1:0]               apu_op_o;
  logic [APU_NDSFLAGS-1:0]          apu_flags_o;
  logic                             apu_rvalid_i;
  logic [31:0]                      apu_rdata_i;
  logic [APU_NUSFLAGS-1:0]          apu_rflags_i;

  modport master (
    output apu_req_o, apu_operands_o, apu_op_o, apu_flags_o,
    input  apu_gnt_i, apu_rvalid_i, apu_rdata_i, apu_rflags_i
  );

  modport slave (
    input  apu_req_o, apu_operands_o, apu_op_o, apu_flags_o,
    output apu_gnt_i, apu_rvalid_i, apu_rdata_i, apu_rflags_i
  );
endinterface

// File: rtl/cv32e40p_apu_arbiter.sv
// rtl/cv32e40p_apu_arbiter.sv - round-robin sharing of one APU/FPU port between NUM_REQ cores
module cv32e40p_apu_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int APU_NARGS       = 3,
  parameter int APU_WOP         = 6,
  parameter int APU_NDSFLAGS    = 15,
  parameter int APU_NUSFLAGS    = 5
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic [NUM_REQ-1:0]                      req_i,
  output logic [NUM_REQ-1:0]                      gnt_o,
  input  logic [NUM_REQ-1:0][APU_NARGS-1:0][31:0] operands_i,
  input  logic [NUM_REQ-1:0][APU_WOP-1:0]         op_i,
  input  logic [NUM_REQ-1:0][APU_NDSFLAGS-1:0]    flags_i,
  output logic [NUM_REQ-1:0]                      rvalid_o,
  output logic [31:0]                             rdata_o,
  output logic [APU_NUSFLAGS-1:0]                 rflags_o,
  cv32e40p_apu_arbiter_if.master                  apu,
  output logic                                    apu_clk_en_o,
  output logic                                    busy_o,
  output logic                                    err_o
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW  = IDW + 1;
  localparam int PW  = $clog2(MAX_OUTSTANDING);
  localparam int CW  = PW + 1;
  localparam logic [SW-1:0]  NREQ = SW'(NUM_REQ);
  localparam logic [IDW-1:0] LAST = IDW'(NUM_REQ - 1);
  localparam logic [CW-1:0]  FULL_CNT = CW'(MAX_OUTSTANDING);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state_q;
  logic [IDW-1:0]   sel_q;
  logic [IDW-1:0]   rr_q;
  logic [IDW-1:0]   fifo_mem [MAX_OUTSTANDING];
  logic [PW-1:0]    wptr_q;
  logic [PW-1:0]    rptr_q;
  logic [CW-1:0]    count_q;
  logic             err_q;

  logic [IDW-1:0]   winner;
  logic [IDW-1:0]   sel;
  logic             req_any;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // Scan from the round-robin pointer upward, wrapping at NUM_REQ.
  always_comb begin
    logic [SW-1:0] idx;
    logic          found;
    winner = rr_q;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, rr_q} + SW'(i);
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_i[idx[IDW-1:0]]) begin
        winner = idx[IDW-1:0];
        found  = 1'b1;
      end
    end
  end

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign sel     = (state_q == LOCKED) ? sel_q : winner;
  assign req_any = (state_q == LOCKED) ? req_i[sel_q] : |req_i;

  assign apu.apu_req_o      = req_any & ~full;
  assign apu.apu_operands_o = operands_i[sel];
  assign apu.apu_op_o       = op_i[sel];
  assign apu.apu_flags_o    = flags_i[sel];

  assign push  = apu.apu_req_o & apu.apu_gnt_i;
  assign pop   = apu.apu_rvalid_i & ~empty;
  assign gnt_o = push ? (NUM_REQ'(1) << sel) : '0;

  assign rvalid_o = pop ? (NUM_REQ'(1) << fifo_mem[rptr_q]) : '0;
  assign rdata_o  = apu.apu_rdata_i;
  assign rflags_o = apu.apu_rflags_i;

  assign busy_o       = ~empty;
  assign apu_clk_en_o = (|req_i) | busy_o;
  assign err_o        = err_q;

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wptr_q] <= sel;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sel_q   <= '0;
      rr_q    <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (apu.apu_rvalid_i && empty) err_q <= 1'b1;
      if (push) rr_q <= (sel == LAST) ? '0 : sel + IDW'(1);
      case (state_q)
        IDLE: begin
          // Only a request actually offered to the FPU gets frozen.
          if (apu.apu_req_o && !apu.apu_gnt_i) begin
            sel_q   <= winner;
            state_q <= LOCKED;
          end
        end
        LOCKED: begin
          if (push || !req_i[sel_q]) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cv32e40p_apu_arbiter.sv
// tb/tb_cv32e40p_apu_arbiter.sv - self-checking bench for cv32e40p_apu_arbiter
module tb_cv32e40p_apu_arbiter;
  localparam int NR  = 2;
  localparam int MO  = 4;
  localparam int NA  = 3;
  localparam int WOP = 6;
  localparam int NDS = 15;
  localparam int NUS = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NR-1:0]               req;
  logic [NR-1:0]               gnt;
  logic [NR-1:0][NA-1:0][31:0] operands;
  logic [NR-1:0][WOP-1:0]      op;
  logic [NR-1:0][NDS-1:0]      flags;
  logic [NR-1:0]               rvalid;
  logic [31:0]                 rdata;
  logic [NUS-1:0]              rflags;
  logic                        clk_en;
  logic                        busy;
  logic                        err;

  cv32e40p_apu_arbiter_if #(.APU_NARGS(NA), .APU_WOP(WOP), .APU_NDSFLAGS(NDS), .APU_NUSFLAGS(NUS)) apu_bus ();

  cv32e40p_apu_arbiter #(
    .NUM_REQ(NR), .MAX_OUTSTANDING(MO), .APU_NARGS(NA),
    .APU_WOP(WOP), .APU_NDSFLAGS(NDS), .APU_NUSFLAGS(NUS)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt),
    .operands_i(operands), .op_i(op), .flags_i(flags),
    .rvalid_o(rvalid), .rdata_o(rdata), .rflags_o(rflags),
    .apu(apu_bus.master), .apu_clk_en_o(clk_en), .busy_o(busy), .err_o(err)
  );

  // Reference model: queue of in-flight core IDs, rr pointer, and the core held while the FPU stalls.
  int  id_q[$];
  int  rr_m;
  int  hold_m;
  bit  err_m;
  int  cand_m;
  bit  offer_m;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic shuffle_ops();
    for (int c = 0; c < NR; c++) begin
      for (int a = 0; a < NA; a++) operands[c][a] = $urandom;
      op[c]    = WOP'($urandom);
      flags[c] = NDS'($urandom);
    end
    apu_bus.apu_rdata_i  = $urandom;
    apu_bus.apu_rflags_i = NUS'($urandom);
  endtask

  task automatic eval();
    logic [NR-1:0] eg;
    logic [NR-1:0] ev;
    #1;
    cand_m = -1;
    if (hold_m >= 0) begin
      if (req[hold_m]) cand_m = hold_m;
    end else begin
      for (int i = 0; i < NR; i++) begin
        int k;
        k = (rr_m + i) % NR;
        if (cand_m < 0 && req[k]) cand_m = k;
      end
    end
    offer_m = (cand_m >= 0) && (id_q.size() < MO);
    eg = '0;
    if (offer_m && apu_bus.apu_gnt_i) eg[cand_m] = 1'b1;
    ev = '0;
    if (apu_bus.apu_rvalid_i && id_q.size() > 0) ev[id_q[0]] = 1'b1;
    chk("apu_req", 128'(apu_bus.apu_req_o), 128'(offer_m));
    chk("gnt", 128'(gnt), 128'(eg));
    chk("rvalid", 128'(rvalid), 128'(ev));
    chk("rdata", 128'(rdata), 128'(apu_bus.apu_rdata_i));
    chk("rflags", 128'(rflags), 128'(apu_bus.apu_rflags_i));
    chk("busy", 128'(busy), 128'(id_q.size() != 0));
    chk("clk_en", 128'(clk_en), 128'((|req) || (id_q.size() != 0)));
    chk("err", 128'(err), 128'(err_m));
    if (offer_m) begin
      chk("operands", 128'(apu_bus.apu_operands_o), 128'(operands[cand_m]));
      chk("op", 128'(apu_bus.apu_op_o), 128'(op[cand_m]));
      chk("flags", 128'(apu_bus.apu_flags_o), 128'(flags[cand_m]));
    end
  endtask

  task automatic tick();
    bit granted;
    @(posedge clk);
    granted = offer_m && apu_bus.apu_gnt_i;
    if (!rst_n) begin
      id_q.delete();
      rr_m   = 0;
      hold_m = -1;
      err_m  = 1'b0;
    end else begin
      if (apu_bus.apu_rvalid_i) begin
        if (id_q.size() > 0) void'(id_q.pop_front());
        else err_m = 1'b1;
      end
      if (granted) begin
        id_q.push_back(cand_m);
        rr_m = (cand_m + 1) % NR;
      end
      if (hold_m >= 0) begin
        if (granted || !req[hold_m]) hold_m = -1;
      end else if (offer_m && !apu_bus.apu_gnt_i) begin
        hold_m = cand_m;
      end
    end
    @(negedge clk);
  endtask

  task automatic cyc();
    eval();
    tick();
  endtask

  task automatic set_in(input logic [NR-1:0] r, input logic g, input logic v);
    req                  = r;
    apu_bus.apu_gnt_i    = g;
    apu_bus.apu_rvalid_i = v;
  endtask

  task automatic do_reset();
    set_in('0, 1'b0, 1'b0);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    id_q.delete();
    rr_m = 0; hold_m = -1; err_m = 1'b0; cand_m = -1; offer_m = 1'b0;
    rst_n = 1'b0;
    set_in('0, 1'b0, 1'b0);
    shuffle_ops();
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset values
    eval();
    chk("reset_gnt", 128'(gnt), 128'(0));
    chk("reset_apu_req", 128'(apu_bus.apu_req_o), 128'(0));
    chk("reset_clk_en", 128'(clk_en), 128'(0));
    chk("reset_busy", 128'(busy), 128'(0));
    tick();
    rst_n = 1'b1;

    // Single core0 request, result three cycles later
    set_in(2'b01, 1'b1, 1'b0);
    eval(); chk("t1_gnt", 128'(gnt), 128'(2'b01)); tick();
    set_in('0, 1'b0, 1'b0);
    cyc(); cyc();
    set_in('0, 1'b0, 1'b1);
    apu_bus.apu_rdata_i = 32'h3F80_0000;
    eval();
    chk("t1_rvalid", 128'(rvalid), 128'(2'b01));
    chk("t1_rdata", 128'(rdata), 128'(32'h3F80_0000));
    tick();
    set_in('0, 1'b0, 1'b0);
    eval(); chk("t1_busy", 128'(busy), 128'(0)); tick();

    // Both cores streaming, grants alternate
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_in(2'b11, 1'b1, 1'b0);
      shuffle_ops();
      eval(); chk("t2_gnt", 128'(gnt), 128'((k % 2 == 0) ? 2'b01 : 2'b10)); tick();
    end
    for (int k = 0; k < 4; k++) begin
      set_in('0, 1'b0, 1'b1);
      eval(); chk("t2_rvalid", 128'(rvalid), 128'((k % 2 == 0) ? 2'b01 : 2'b10)); tick();
    end

    // FPU stalls core1 while core0 also asks
    do_reset();
    set_in(2'b10, 1'b0, 1'b0);
    cyc();
    for (int k = 0; k < 3; k++) begin
      set_in(2'b11, 1'b0, 1'b0);
      shuffle_ops();
      eval();
      chk("t3_hold_ops", 128'(apu_bus.apu_operands_o), 128'(operands[1]));
      chk("t3_hold_gnt", 128'(gnt), 128'(0));
      tick();
    end
    set_in(2'b11, 1'b1, 1'b0);
    eval(); chk("t3_gnt1", 128'(gnt), 128'(2'b10)); tick();
    eval(); chk("t3_gnt0", 128'(gnt), 128'(2'b01)); tick();
    set_in('0, 1'b0, 1'b1);
    cyc(); cyc();

    // FIFO full blocks the fifth request, even on a same-cycle pop
    do_reset();
    set_in(2'b01, 1'b1, 1'b0);
    repeat (4) cyc();
    eval();
    chk("t4_full_req", 128'(apu_bus.apu_req_o), 128'(0));
    chk("t4_full_gnt", 128'(gnt), 128'(0));
    tick();
    set_in(2'b01, 1'b1, 1'b1);
    eval();
    chk("t4_pop_gnt", 128'(gnt), 128'(0));
    chk("t4_pop_rvalid", 128'(rvalid), 128'(2'b01));
    tick();
    set_in(2'b01, 1'b1, 1'b0);
    eval(); chk("t4_resume_gnt", 128'(gnt), 128'(2'b01)); tick();
    set_in('0, 1'b0, 1'b1);
    repeat (4) cyc();

    // Spurious response with empty FIFO
    do_reset();
    set_in('0, 1'b0, 1'b1);
    eval(); chk("t5_rvalid", 128'(rvalid), 128'(0)); tick();
    set_in('0, 1'b0, 1'b0);
    eval(); chk("t5_err", 128'(err), 128'(1)); tick();
    cyc();
    rst_n = 1'b0;
    eval(); chk("t5_err_hold", 128'(err), 128'(1)); tick();
    rst_n = 1'b1;
    eval(); chk("t5_err_clr", 128'(err), 128'(0)); tick();

    // Reset with two in flight
    set_in(2'b01, 1'b1, 1'b0);
    cyc(); cyc();
    set_in('0, 1'b0, 1'b0);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    eval();
    chk("t6_busy", 128'(busy), 128'(0));
    chk("t6_clk_en", 128'(clk_en), 128'(0));
    tick();
    set_in('0, 1'b0, 1'b1);
    cyc();
    set_in('0, 1'b0, 1'b0);
    eval(); chk("t6_late_err", 128'(err), 128'(1)); tick();
    set_in(2'b11, 1'b1, 1'b0);
    eval(); chk("t6_gnt", 128'(gnt), 128'(2'b01)); tick();

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      shuffle_ops();
      req                  = NR'($urandom);
      apu_bus.apu_gnt_i    = ($urandom_range(0, 3) != 0);
      apu_bus.apu_rvalid_i = (id_q.size() > 0) ? ($urandom_range(0, 2) == 0)
                                               : ($urandom_range(0, 199) == 0);
      rst_n = ($urandom_range(0, 249) != 0);
      cyc();
    end
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
